registro_universal_n: RTL and testbench
=======================================

# registro_universal_n

Parametrised universal register: the edge-triggered, multi-mode successor of the 4-bit level-sensitive latch register. It holds `WIDTH` bits and, under a 3-bit mode select, performs hold, parallel load, logical shift in either direction with serial input, rotate in either direction, or synchronous clear. A saturating shift counter flags when a full word has been shifted since the last load or clear. It sits on datapaths as a storage register and as a serial↔parallel converter.

## Interface
- `WIDTH`, default 4: register width in bits; must be ≥ 2.
- `CW`, default `$clog2(WIDTH+1)`: shift-counter width. Derived; not overridden.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `enable` input 1: when 0, all state holds regardless of `modo`.
- `modo` input 3: operation select (see Operation).
- `B` input WIDTH: parallel load data.
- `sir` input 1: serial in for shift right; enters the MSB.
- `sil` input 1: serial in for shift left; enters the LSB.
- `sQ` output WIDTH: register contents (registered).
- `sor` output 1: serial out right, = `sQ[0]` (combinational from state).
- `sol` output 1: serial out left, = `sQ[WIDTH-1]`.
- `cnt` output CW: shifts/rotates since last load or clear, saturating at WIDTH.
- `done` output 1: = (`cnt` == WIDTH).

## Operation
- Reset (`rst_n`=0, asynchronous, at any time): `sQ`=0, `cnt`=0, hence `done`=0, `sor`=0, `sol`=0. Reset overrides every mode, including mid-shift.
- `enable`=0: `sQ` and `cnt` hold.
- `enable`=1, on the rising edge, by `modo`:
  - 000 HOLD: no change.
  - 001 SHR: `sQ` ← {`sir`, `sQ[WIDTH-1:1]`}; `cnt`+1.
  - 010 SHL: `sQ` ← {`sQ[WIDTH-2:0]`, `sil`}; `cnt`+1.
  - 011 LOAD: `sQ` ← `B`; `cnt` ← 0.
  - 100 ROR: `sQ` ← {`sQ[0]`, `sQ[WIDTH-1:1]`}; `cnt`+1.
  - 101 ROL: `sQ` ← {`sQ[WIDTH-2:0]`, `sQ[WIDTH-1]`}; `cnt`+1.
  - 110 CLR: `sQ` ← 0; `cnt` ← 0.
  - 111 reserved: behaves as HOLD.
- Counter: increments only on SHR/SHL/ROR/ROL. At WIDTH it saturates (no wrap). `sQ` keeps shifting after saturation. Mixing directions still counts each operation.
- No latch inference: every register has an explicit value on every path. The level-transparent behaviour of the earlier block is not retained.

## Timing
- One-cycle latency: the effect of `modo`, `B`, `sir`, `sil` sampled at edge k is visible on `sQ`/`cnt` after edge k.
- `sor`, `sol`, and `done` are purely combinational decodes of registered state, with no extra cycle.
- From LOAD, `done` rises exactly WIDTH enabled shift edges later. With `enable` gaps, it rises on the WIDTH-th enabled shift edge.
- `rst_n` deassertion has no synchronous effect of its own. The first edge with `rst_n`=1 applies `modo` normally.
- No handshake is required: the block accepts an operation every cycle.

## Structure
- Shared package `registro_pkg` holds the mode encodings as named constants `MODO_HOLD`, `MODO_SHR`, `MODO_SHL`, `MODO_LOAD`, `MODO_ROR`, `MODO_ROL`, `MODO_CLR`, `MODO_RSV`, and the 3-bit mode typedef. The bench imports the same package.
- One natural sub-module, `contador_sat`: a CW-bit saturating counter with inputs `inc`, `clr`, `max` = WIDTH, and async active-low reset. The data register stays in the top as a single `case` on `modo`.

## Test plan
- Reset mid-operation: WIDTH=4, LOAD `B`=1011, then SHR twice, then assert `rst_n`=0 between edges → `sQ`=0000 and `cnt`=0 immediately, without waiting for an edge.
- Serial-in right: after CLR, SHR four times with `sir`=1,0,1,1 → `sQ`=1101, `sor` sequence 0,0,0,1 after each edge, `done`=1 after the fourth edge only.
- Parallel-to-serial left: LOAD 1001, then SHL ×4 with `sil`=0 → `sol` emits 1,0,0,1 (before each edge), final `sQ`=0000, `cnt`=4, `done`=1. A fifth SHL → `cnt` stays 4.
- Rotate: LOAD 0011, ROR → 1001, ROR → 1100, ROL → 1001. `cnt`=3, and LOAD resets it to 0.
- Enable/reserved: LOAD 0110, then `enable`=0 with `modo`=SHR for 3 cycles → `sQ`=0110, `cnt`=0. Then `enable`=1 with `modo`=111 → unchanged.
- Width sweep: repeat the serial-in scenario with WIDTH=8, shifting 0xA5 in via `sir` LSB-first → `sQ`=8'hA5, and `done` rises exactly on the 8th shift.

Source files
------------

// File: rtl/registro_pkg.sv
// Shared mode encodings for the universal register family.
package registro_pkg;

    typedef logic [2:0] modo_t;

    localparam modo_t MODO_HOLD = 3'b000;
    localparam modo_t MODO_SHR  = 3'b001;
    localparam modo_t MODO_SHL  = 3'b010;
    localparam modo_t MODO_LOAD = 3'b011;
    localparam modo_t MODO_ROR  = 3'b100;
    localparam modo_t MODO_ROL  = 3'b101;
    localparam modo_t MODO_CLR  = 3'b110;
    localparam modo_t MODO_RSV  = 3'b111;

    // True for the operations that move bits and therefore advance the shift counter.
    function automatic logic es_desplazamiento(input modo_t m);
        return (m == MODO_SHR) || (m == MODO_SHL) || (m == MODO_ROR) || (m == MODO_ROL);
    endfunction

endpackage

// File: rtl/registro_universal_n_contador_sat.sv
// Saturating up-counter: clr wins over inc, and the count sticks at MAX.
module contador_sat #(
    parameter int unsigned CW  = 3,
    parameter int unsigned MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] cnt
);

    logic [CW-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt;
        if (clr) begin
            cnt_next = '0;
        end else if (inc && (cnt != CW'(MAX))) begin
            cnt_next = cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/registro_universal_n.sv
// Universal WIDTH-bit register: hold, load, shift, rotate and clear, with a
// saturating count of shifts since the last load or clear.
module registro_universal_n
    import registro_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  modo_t            modo,
    input  logic [WIDTH-1:0] B,
    input  logic             sir,
    input  logic             sil,
    output logic [WIDTH-1:0] sQ,
    output logic             sor,
    output logic             sol,
    output logic [CW-1:0]    cnt,
    output logic             done
);

    logic [WIDTH-1:0] q_next;
    logic             cnt_inc;
    logic             cnt_clr;

    // Next data word; every mode assigns, so nothing is inferred as a latch.
    always_comb begin
        q_next = sQ;
        if (enable) begin
            case (modo)
                MODO_SHR:  q_next = {sir, sQ[WIDTH-1:1]};
                MODO_SHL:  q_next = {sQ[WIDTH-2:0], sil};
                MODO_LOAD: q_next = B;
                MODO_ROR:  q_next = {sQ[0], sQ[WIDTH-1:1]};
                MODO_ROL:  q_next = {sQ[WIDTH-2:0], sQ[WIDTH-1]};
                MODO_CLR:  q_next = '0;
                default:   q_next = sQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sQ <= '0;
        end else begin
            sQ <= q_next;
        end
    end

    always_comb begin
        cnt_inc = enable && es_desplazamiento(modo);
        cnt_clr = enable && ((modo == MODO_LOAD) || (modo == MODO_CLR));
    end

    contador_sat #(
        .CW  (CW),
        .MAX (WIDTH)
    ) u_contador (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (cnt_inc),
        .clr   (cnt_clr),
        .cnt   (cnt)
    );

    // Serial outs and done are plain decodes of registered state.
    assign sor  = sQ[0];
    assign sol  = sQ[WIDTH-1];
    assign done = (cnt == CW'(WIDTH));

endmodule

// File: tb/tb_registro_universal_n.sv
// Directed bench for registro_universal_n at WIDTH=4 (vector table) and WIDTH=8.
module tb_registro_universal_n;
    import registro_pkg::*;

    logic       clk;
    logic       rst_n;

    logic       en4, sir4, sil4;
    modo_t      modo4;
    logic [3:0] b4, q4;
    logic [2:0] cnt4;
    logic       sor4, sol4, done4;

    logic       en8, sir8, sil8;
    modo_t      modo8;
    logic [7:0] b8, q8;
    logic [3:0] cnt8;
    logic       sor8, sol8, done8;

    int checks = 0;
    int errors = 0;

    registro_universal_n #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .enable(en4), .modo(modo4), .B(b4),
        .sir(sir4), .sil(sil4), .sQ(q4), .sor(sor4), .sol(sol4),
        .cnt(cnt4), .done(done4)
    );

    registro_universal_n #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .enable(en8), .modo(modo8), .B(b8),
        .sir(sir8), .sil(sil8), .sQ(q8), .sor(sor8), .sol(sol8),
        .cnt(cnt8), .done(done8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       en;
        modo_t      m;
        logic [3:0] b;
        logic       sir;
        logic       sil;
        logic [3:0] q;
        logic [2:0] c;
    } vec_t;

    localparam int unsigned NV = 24;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check4(input string tag, input logic [3:0] eq, input logic [2:0] ec);
        check({tag, " sQ"},   32'(q4),    32'(eq));
        check({tag, " cnt"},  32'(cnt4),  32'(ec));
        check({tag, " done"}, 32'(done4), 32'(ec == 3'd4));
        check({tag, " sor"},  32'(sor4),  32'(eq[0]));
        check({tag, " sol"},  32'(sol4),  32'(eq[3]));
    endtask

    task automatic drive4(input logic en, input modo_t m, input logic [3:0] b,
                          input logic si_r, input logic si_l);
        @(negedge clk);
        en4 = en; modo4 = m; b4 = b; sir4 = si_r; sil4 = si_l;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] pat;
        logic [7:0] exp8;
        logic [3:0] sol_seq;
        logic [3:0] ld;

        vecs[0]  = '{1'b1, MODO_LOAD, 4'b1011, 1'b0, 1'b0, 4'b1011, 3'd0};
        vecs[1]  = '{1'b1, MODO_CLR,  4'b1111, 1'b0, 1'b0, 4'b0000, 3'd0};
        vecs[2]  = '{1'b1, MODO_SHR,  4'b0000, 1'b1, 1'b0, 4'b1000, 3'd1};
        vecs[3]  = '{1'b1, MODO_SHR,  4'b0000, 1'b0, 1'b0, 4'b0100, 3'd2};
        vecs[4]  = '{1'b1, MODO_SHR,  4'b0000, 1'b1, 1'b0, 4'b1010, 3'd3};
        vecs[5]  = '{1'b1, MODO_SHR,  4'b0000, 1'b1, 1'b0, 4'b1101, 3'd4};
        vecs[6]  = '{1'b1, MODO_LOAD, 4'b1001, 1'b0, 1'b0, 4'b1001, 3'd0};
        vecs[7]  = '{1'b1, MODO_SHL,  4'b0000, 1'b0, 1'b0, 4'b0010, 3'd1};
        vecs[8]  = '{1'b1, MODO_SHL,  4'b0000, 1'b0, 1'b0, 4'b0100, 3'd2};
        vecs[9]  = '{1'b1, MODO_SHL,  4'b0000, 1'b0, 1'b0, 4'b1000, 3'd3};
        vecs[10] = '{1'b1, MODO_SHL,  4'b0000, 1'b0, 1'b0, 4'b0000, 3'd4};
        vecs[11] = '{1'b1, MODO_SHL,  4'b0000, 1'b0, 1'b0, 4'b0000, 3'd4};
        vecs[12] = '{1'b1, MODO_LOAD, 4'b0011, 1'b0, 1'b0, 4'b0011, 3'd0};
        vecs[13] = '{1'b1, MODO_ROR,  4'b0000, 1'b0, 1'b0, 4'b1001, 3'd1};
        vecs[14] = '{1'b1, MODO_ROR,  4'b0000, 1'b0, 1'b0, 4'b1100, 3'd2};
        vecs[15] = '{1'b1, MODO_ROL,  4'b0000, 1'b0, 1'b0, 4'b1001, 3'd3};
        vecs[16] = '{1'b1, MODO_LOAD, 4'b0110, 1'b0, 1'b0, 4'b0110, 3'd0};
        vecs[17] = '{1'b0, MODO_SHR,  4'b0000, 1'b1, 1'b0, 4'b0110, 3'd0};
        vecs[18] = '{1'b0, MODO_SHR,  4'b0000, 1'b1, 1'b0, 4'b0110, 3'd0};
        vecs[19] = '{1'b0, MODO_SHR,  4'b0000, 1'b1, 1'b0, 4'b0110, 3'd0};
        vecs[20] = '{1'b1, MODO_RSV,  4'b1111, 1'b1, 1'b1, 4'b0110, 3'd0};
        vecs[21] = '{1'b1, MODO_HOLD, 4'b1111, 1'b1, 1'b1, 4'b0110, 3'd0};
        vecs[22] = '{1'b1, MODO_SHR,  4'b0000, 1'b0, 1'b1, 4'b0011, 3'd1};
        vecs[23] = '{1'b1, MODO_SHL,  4'b0000, 1'b0, 1'b1, 4'b0111, 3'd2};

        rst_n = 1'b0;
        en4 = 1'b0; modo4 = MODO_HOLD; b4 = '0; sir4 = 1'b0; sil4 = 1'b0;
        en8 = 1'b0; modo8 = MODO_HOLD; b8 = '0; sir8 = 1'b0; sil8 = 1'b0;
        repeat (2) @(negedge clk);
        check4("reset", 4'b0000, 3'd0);
        check("reset8 sQ", 32'(q8), 32'h0);
        rst_n = 1'b1;

        // Table-driven WIDTH=4 sequence
        for (int i = 0; i < int'(NV); i++) begin
            drive4(vecs[i].en, vecs[i].m, vecs[i].b, vecs[i].sir, vecs[i].sil);
            check4($sformatf("vec%0d", i), vecs[i].q, vecs[i].c);
        end

        // sol before each SHL edge after LOAD 1001 must be 1,0,0,1
        drive4(1'b1, MODO_LOAD, 4'b1001, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            sol_seq[3 - i] = sol4;
            drive4(1'b1, MODO_SHL, 4'b0000, 1'b0, 1'b0);
        end
        check("sol stream", 32'(sol_seq), 32'b1001);
        check4("p2s end", 4'b0000, 3'd4);

        // done across enable gaps rises on the 4th enabled shift
        drive4(1'b1, MODO_LOAD, 4'b0101, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive4(1'b0, MODO_ROL, 4'b0000, 1'b0, 1'b0);
            check($sformatf("gap%0d done", i), 32'(done4), 32'(0));
            drive4(1'b1, MODO_ROL, 4'b0000, 1'b0, 1'b0);
            check($sformatf("gap%0d cnt", i), 32'(cnt4), 32'(i + 1));
        end
        check("gap sQ", 32'(q4), 32'b0101);
        check("gap done", 32'(done4), 32'(1));

        // Asynchronous reset mid-shift, between edges
        drive4(1'b1, MODO_LOAD, 4'b1011, 1'b0, 1'b0);
        drive4(1'b1, MODO_SHR, 4'b0000, 1'b0, 1'b0);
        drive4(1'b1, MODO_SHR, 4'b0000, 1'b0, 1'b0);
        check4("pre-reset", 4'b0010, 3'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check4("async reset", 4'b0000, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ld = 4'b1110;
        drive4(1'b1, MODO_LOAD, ld, 1'b0, 1'b0);
        check4("post-reset load", ld, 3'd0);

        // WIDTH=8: shift 0xA5 in LSB-first via sir
        pat = 8'hA5;
        @(negedge clk);
        en8 = 1'b1; modo8 = MODO_CLR;
        @(posedge clk);
        #1;
        check("w8 clr", 32'(q8), 32'h0);
        exp8 = 8'h00;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            modo8 = MODO_SHR; sir8 = pat[i];
            @(posedge clk);
            #1;
            exp8 = {pat[i], exp8[7:1]};
            check($sformatf("w8 sh%0d sQ", i), 32'(q8), 32'(exp8));
            check($sformatf("w8 sh%0d done", i), 32'(done8), 32'(i == 7));
        end
        check("w8 final", 32'(q8), 32'hA5);
        check("w8 cnt", 32'(cnt8), 32'd8);
        check("w8 sor", 32'(sor8), 32'(1));
        check("w8 sol", 32'(sol8), 32'(1));
        @(negedge clk);
        modo8 = MODO_ROL;
        @(posedge clk);
        #1;
        check("w8 rol", 32'(q8), 32'h4B);
        check("w8 sat", 32'(cnt8), 32'd8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
